// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int MAX_STREAK_DEFAULT = 4;
    localparam int STREAK_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IF,
        GRANT_MEM,
        RESP
    } arb_state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Counts consecutive data-port grants taken while a fetch was waiting,
// so the arbiter can hand the memory to the fetch port once it saturates.
module arb_streak_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = MAX_STREAK_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STREAK_W-1:0] MAX_VAL = STREAK_W'(MAX);

    logic [STREAK_W-1:0] count;

    // Clear has priority: an IF grant or an uncontested MEM grant restarts the streak.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == MAX_VAL);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port RAM between an instruction fetch port and a data port.
// Data accesses win unless the fetch port has been starved for MAX_STREAK grants.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,

    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t        state;
    arb_state_t        state_next;

    logic              ram_en_next;
    logic              ram_we_next;
    logic [ADDR_W-1:0] ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_next;
    logic [DATA_W-1:0] if_rdata_next;
    logic [DATA_W-1:0] mem_rdata_next;
    logic              if_ack_next;
    logic              mem_ack_next;

    logic              streak_inc;
    logic              streak_clr;
    logic              streak_sat;
    logic              mem_wins;

    arb_streak_counter #(
        .MAX (MAX_STREAK)
    ) u_streak (
        .clock (clock),
        .reset (reset),
        .inc   (streak_inc),
        .clr   (streak_clr),
        .sat   (streak_sat)
    );

    // Every RAM-side and response output is computed here and registered below,
    // so the RAM sees the latched request rather than the live port inputs.
    always_comb begin
        state_next     = state;
        ram_en_next    = ram_en;
        ram_we_next    = ram_we;
        ram_addr_next  = ram_addr;
        ram_wdata_next = ram_wdata;
        if_rdata_next  = if_rdata;
        mem_rdata_next = mem_rdata;
        if_ack_next    = 1'b0;
        mem_ack_next   = 1'b0;
        streak_inc     = 1'b0;
        streak_clr     = 1'b0;
        mem_wins       = mem_req && !(if_req && streak_sat);

        case (state)
            IDLE: begin
                if (mem_wins) begin
                    state_next     = GRANT_MEM;
                    ram_en_next    = 1'b1;
                    ram_we_next    = mem_we;
                    ram_addr_next  = mem_addr;
                    ram_wdata_next = mem_wdata;
                    streak_inc     = if_req;
                    streak_clr     = !if_req;
                end else if (if_req) begin
                    state_next     = GRANT_IF;
                    ram_en_next    = 1'b1;
                    ram_we_next    = 1'b0;
                    ram_addr_next  = if_addr;
                    ram_wdata_next = '0;
                    streak_clr     = 1'b1;
                end
            end
            GRANT_IF: begin
                if (ram_ready) begin
                    state_next    = RESP;
                    ram_en_next   = 1'b0;
                    ram_we_next   = 1'b0;
                    if_rdata_next = ram_rdata;
                    if_ack_next   = 1'b1;
                end
            end
            GRANT_MEM: begin
                if (ram_ready) begin
                    state_next   = RESP;
                    ram_en_next  = 1'b0;
                    ram_we_next  = 1'b0;
                    mem_ack_next = 1'b1;
                    // A completed store must not disturb the last load result.
                    if (!ram_we) begin
                        mem_rdata_next = ram_rdata;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next  = IDLE;
                ram_en_next = 1'b0;
                ram_we_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
        end else begin
            state     <= state_next;
            ram_en    <= ram_en_next;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_wdata <= ram_wdata_next;
            if_rdata  <= if_rdata_next;
            mem_rdata <= mem_rdata_next;
            if_ack    <= if_ack_next;
            mem_ack   <= mem_ack_next;
        end
    end

    assign stall_if  = if_req  & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: inputs change and outputs are sampled
// on the falling clock edge, so every check sees settled registered outputs.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        stall_if;
    logic        stall_mem;

    int errors;
    int checks;

    always #5 clock = ~clock;

    memory_port_arbiter #(
        .MAX_STREAK (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic mreq, input logic mwe,
                                 input logic [31:0] maddr, input logic [31:0] mwdata);
        if_req    = ireq;
        if_addr   = iaddr;
        mem_req   = mreq;
        mem_we    = mwe;
        mem_addr  = maddr;
        mem_wdata = mwdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] seq [10];
        int         n;

        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        ram_ready = 1'b0;
        ram_rdata = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 10; k++) seq[k] = 2'b00;

        // Reset values.
        repeat (2) @(negedge clock);
        checkOutput("rst_ram_en",    {31'b0, ram_en},  32'h0);
        checkOutput("rst_ram_we",    {31'b0, ram_we},  32'h0);
        checkOutput("rst_ram_addr",  ram_addr,         32'h0);
        checkOutput("rst_ram_wdata", ram_wdata,        32'h0);
        checkOutput("rst_if_ack",    {31'b0, if_ack},  32'h0);
        checkOutput("rst_mem_ack",   {31'b0, mem_ack}, 32'h0);
        checkOutput("rst_if_rdata",  if_rdata,         32'h0);
        checkOutput("rst_mem_rdata", mem_rdata,        32'h0);

        // Fetch only, request arrives with reset release: first edge grants.
        reset = 1'b1;
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        checkOutput("if_ram_en",   {31'b0, ram_en},   32'h1);
        checkOutput("if_ram_addr", ram_addr,          32'h0000_0010);
        checkOutput("if_ram_we",   {31'b0, ram_we},   32'h0);
        checkOutput("if_ack_early", {31'b0, if_ack},  32'h0);
        checkOutput("if_stall",    {31'b0, stall_if}, 32'h1);
        ram_ready = 1'b1;
        ram_rdata = 32'h0000_0013;
        @(negedge clock);
        checkOutput("if_ack",      {31'b0, if_ack},   32'h1);
        checkOutput("if_rdata",    if_rdata,          32'h0000_0013);
        checkOutput("if_resp_en",  {31'b0, ram_en},   32'h0);
        checkOutput("if_stall_ack", {31'b0, stall_if}, 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        ram_rdata = 32'h0000_0055;

        // ram_ready left high through RESP and IDLE must be ignored.
        @(negedge clock);
        checkOutput("spur_if_ack",   {31'b0, if_ack},  32'h0);
        checkOutput("spur_ram_en",   {31'b0, ram_en},  32'h0);
        checkOutput("spur_if_rdata", if_rdata,         32'h0000_0013);
        @(negedge clock);
        checkOutput("spur_idle_en",  {31'b0, ram_en},  32'h0);
        checkOutput("spur_mem_ack",  {31'b0, mem_ack}, 32'h0);
        checkOutput("spur_mem_rdata", mem_rdata,       32'h0);
        ram_ready = 1'b0;

        // Simultaneous requests: load wins first, fetch follows.
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111);
        @(negedge clock);
        checkOutput("both_mem_en",   {31'b0, ram_en}, 32'h1);
        checkOutput("both_mem_addr", ram_addr,        32'h0000_0100);
        checkOutput("both_mem_we",   {31'b0, ram_we}, 32'h0);
        mem_addr  = 32'h0000_0999;
        ram_ready = 1'b1;
        ram_rdata = 32'h1234_5678;
        @(negedge clock);
        checkOutput("both_mem_ack",   {31'b0, mem_ack}, 32'h1);
        checkOutput("both_mem_rdata", mem_rdata,        32'h1234_5678);
        checkOutput("both_if_noack",  {31'b0, if_ack},  32'h0);
        checkOutput("both_latched",   ram_addr,         32'h0000_0100);
        mem_req   = 1'b0;
        ram_ready = 1'b0;
        @(negedge clock);
        checkOutput("both_idle_en",   {31'b0, ram_en},  32'h0);
        checkOutput("both_ack_pulse", {31'b0, mem_ack}, 32'h0);
        @(negedge clock);
        checkOutput("both_if_en",   {31'b0, ram_en}, 32'h1);
        checkOutput("both_if_addr", ram_addr,        32'h0000_0040);
        checkOutput("both_if_we",   {31'b0, ram_we}, 32'h0);
        ram_ready = 1'b1;
        ram_rdata = 32'h0000_0077;
        @(negedge clock);
        checkOutput("both_if_ack",    {31'b0, if_ack}, 32'h1);
        checkOutput("both_if_rdata",  if_rdata,        32'h0000_0077);
        checkOutput("both_mem_hold",  mem_rdata,       32'h1234_5678);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        ram_ready = 1'b0;
        @(negedge clock);

        // Store with a slow RAM: request held three cycles.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput($sformatf("st_en%0d", i),    {31'b0, ram_en},    32'h1);
            checkOutput($sformatf("st_we%0d", i),    {31'b0, ram_we},    32'h1);
            checkOutput($sformatf("st_wd%0d", i),    ram_wdata,          32'hDEAD_BEEF);
            checkOutput($sformatf("st_addr%0d", i),  ram_addr,           32'h0000_0200);
            checkOutput($sformatf("st_stall%0d", i), {31'b0, stall_mem}, 32'h1);
            checkOutput($sformatf("st_ack%0d", i),   {31'b0, mem_ack},   32'h0);
            if (i == 2) begin
                ram_ready = 1'b1;
                ram_rdata = 32'h0000_CAFE;
            end
        end
        @(negedge clock);
        checkOutput("st_ack",      {31'b0, mem_ack},   32'h1);
        checkOutput("st_stall",    {31'b0, stall_mem}, 32'h0);
        checkOutput("st_rdata",    mem_rdata,          32'h1234_5678);
        checkOutput("st_resp_en",  {31'b0, ram_en},    32'h0);
        mem_req   = 1'b0;
        ram_ready = 1'b0;
        @(negedge clock);
        checkOutput("st_ack_pulse", {31'b0, mem_ack}, 32'h0);

        // Reset in the middle of a load abandons it; the held request is re-granted.
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_0300, '0);
        @(negedge clock);
        checkOutput("rg_en", {31'b0, ram_en}, 32'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rg_async_en",   {31'b0, ram_en},  32'h0);
        checkOutput("rg_async_addr", ram_addr,         32'h0);
        checkOutput("rg_async_ack",  {31'b0, mem_ack}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rg_noack",  {31'b0, mem_ack}, 32'h0);
        checkOutput("rg_regrant", {31'b0, ram_en}, 32'h1);
        checkOutput("rg_addr",   ram_addr,         32'h0000_0300);
        ram_ready = 1'b1;
        ram_rdata = 32'h0000_ABCD;
        @(negedge clock);
        checkOutput("rg_ack",   {31'b0, mem_ack}, 32'h1);
        checkOutput("rg_rdata", mem_rdata,        32'h0000_ABCD);
        mem_req   = 1'b0;
        ram_ready = 1'b0;
        @(negedge clock);

        // Both ports requesting continuously: four loads, then one fetch, repeating.
        applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0500, '0);
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clock);
            if (if_ack || mem_ack) begin
                seq[n] = {if_ack, mem_ack};
                n++;
            end
            ram_ready = ram_en;
            ram_rdata = 32'(c);
        end
        checkOutput("streak_count", 32'(n), 32'd10);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("streak_ack%0d", k), {30'b0, seq[k]},
                        (k % 5 == 4) ? 32'h2 : 32'h1);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        ram_ready = 1'b0;
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter: MAX_STREAK, 4, max consecutive MEM grants while IF waits (range 1..15).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  fetch request, held until if_ack.
REQ-006 if_addr  in  32  fetch address, stable while if_req.
REQ-007 if_rdata  out  32  fetched instruction, valid when if_ack.
REQ-008 if_ack  out  1  one-cycle completion pulse for fetch.
REQ-009 mem_req  in  1  data request, held until mem_ack.
REQ-010 mem_we  in  1  1 = store, 0 = load.
REQ-011 mem_addr  in  32  data address.
REQ-012 mem_wdata  in  32  store data.
REQ-013 mem_rdata  out  32  load data, valid when mem_ack.
REQ-014 mem_ack  out  1  one-cycle completion pulse for data access.
REQ-015 ram_en  out  1  memory access strobe, held until ram_ready.
REQ-016 ram_we  out  1  memory write enable.
REQ-017 ram_addr  out  32  memory address.
REQ-018 ram_wdata  out  32  memory write data.
REQ-019 ram_rdata  in  32  memory read data, valid with ram_ready.
REQ-020 ram_ready  in  1  memory completion, sampled only while ram_en=1.
REQ-021 stall_if  out  1  combinational: if_req & ~if_ack.
REQ-022 stall_mem  out  1  combinational: mem_req & ~mem_ack.

Function
REQ-023 FSM states IDLE, GRANT_IF, GRANT_MEM, RESP; all outputs registered except stall_if/stall_mem.
REQ-024 IDLE: no request -> stay; grant decision per REQ-025; winner's address/we/wdata latched on the transition edge.
REQ-025 Priority: MEM wins, except when if_req=1 and streak == MAX_STREAK, then IF wins.
REQ-026 streak: increments (saturating at MAX_STREAK) on each MEM grant taken while if_req=1; cleared to 0 on IF grant or any MEM grant taken with if_req=0.
REQ-027 GRANT_x: ram_en=1, ram_addr/ram_we/ram_wdata = latched values (ram_we=0 in GRANT_IF); stay until ram_ready=1.
REQ-028 On ram_ready=1 in GRANT_x: capture ram_rdata into x_rdata, go to RESP, pulse x_ack=1 for exactly the RESP cycle, ram_en=0 in RESP.
REQ-029 RESP -> IDLE unconditionally; requests are never sampled in RESP, so a requester drops req on the edge ending its ack cycle with no duplicate grant.
REQ-030 Minimum latency: req sampled in cycle N, ram_en in N+1, ram_ready in N+1 -> ack in N+2; one access per 3 cycles peak.
REQ-031 if_rdata/mem_rdata hold last captured value until next completion of the same port; store completion leaves mem_rdata unchanged.
REQ-032 Inputs of the non-granted port are ignored; change of granted port's address mid-grant has no effect (latched copy used).
REQ-033 ram_ready while ram_en=0 SHALL be ignored.

Reset
REQ-034 reset=0 asynchronously forces IDLE, streak=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0.
REQ-035 Reset during GRANT_x or RESP abandons the access: no ack issued after reset release; requester re-arbitrates from IDLE.
REQ-036 First grant possible in the first clock edge after reset release.

Structure
REQ-037 Shared package mem_arb_pkg SHALL hold the state enum, MAX_STREAK default and 32-bit address/data width constants.
REQ-038 Streak logic SHALL be one sub-module arb_streak_counter (inc, clr, sat flag); rest is a single FSM module.

Verification
REQ-039 IF only, addr 0x0000_0010, ram_ready immediate, ram_rdata 0x0000_0013 -> ram_en cycle N+1, if_ack cycle N+2, if_rdata=0x0000_0013.
REQ-040 Simultaneous if_req and mem_req (load 0x100) -> MEM granted first, IF granted in next IDLE, ram_we=0 both.
REQ-041 MAX_STREAK=4, mem_req permanently high, if_req high -> exactly 4 MEM acks then one IF ack, pattern repeats.
REQ-042 Store addr 0x200 data 0xDEAD_BEEF, ram_ready delayed 3 cycles -> ram_en/ram_we/ram_wdata held 3 cycles, mem_ack one cycle, stall_mem high until ack.
REQ-043 reset asserted in GRANT_MEM -> ram_en=0 immediately, no mem_ack after release, next mem_req re-granted from IDLE.
REQ-044 Spurious ram_ready in IDLE/RESP -> no ack, no state change.
